wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Three-master, one-slave Wishbone classic arbiter for the MIPS core bus.
- Masters: m0 = icache refill, m1 = data port, m2 = debug/DMA.
- Grants are round-robin and locked for the whole CYC of the granted master.
- A watchdog terminates stalled cycles with an error strobe, so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 64: cycles with STB high and no ACK before a forced error. Legal range 2..255.
- CNT_W, 8: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_mX_cyc (X=0..2)  input  1  master X bus cycle request.
- i_mX_stb (X=0..2)  input  1  master X strobe.
- i_mX_we (X=0..2)  input  1  master X write enable.
- i_mX_sel (X=0..2)  input  4  master X byte selects.
- i_mX_adr (X=0..2)  input  30  master X word address.
- i_mX_dat (X=0..2)  input  32  master X write data.
- o_mX_ack (X=0..2)  output  1  ack routed to master X.
- o_mX_err (X=0..2)  output  1  timeout error to master X.
- o_mX_dat (X=0..2)  output  32  read data to master X.
- o_wb_cyc  output  1  slave cycle.
- o_wb_stb  output  1  slave strobe.
- o_wb_we  output  1  slave write enable.
- o_wb_sel  output  4  slave byte selects.
- o_wb_adr  output  30  slave word address.
- o_wb_dat  output  32  slave write data.
- i_wb_ack  input  1  slave ack.
- i_wb_dat  input  32  slave read data.
- o_grant  output  2  current owner: 0/1/2, 3 = none.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_grant=3, last_grant=2 (so m0 has first priority), watchdog=0.
  - All o_wb_* outputs 0; all acks and errors 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Slave outputs forced 0.
  - If any i_mX_cyc=1, pick the first requester scanning from last_grant+1 (mod 3), wrapping.
  - Register that master as the grant and move to BUSY on the next edge. Arbitration latency is 1 cycle.
- BUSY:
  - Slave outputs combinationally follow the granted master's cyc/stb/we/sel/adr/dat.
  - o_wb_stb is forced 0 on any cycle in which o_mX_err fires.
  - Granted master: o_mX_ack = i_wb_ack & i_mX_stb.
  - Non-granted masters: ack and err are held 0.
  - o_mX_dat = i_wb_dat for all masters (shared bus; qualified by ack).
- Release:
  - When the granted master's i_mX_cyc=0 in BUSY, go to IDLE on the next edge and set last_grant = grant.
  - Grant is held across back-to-back strobes while cyc stays high (block transfers, RMW). No preemption.
- Re-arbitration: a master requesting in the cycle its peer releases is granted after one IDLE cycle. This gives a minimum 1-cycle bus turnaround.
- Watchdog:
  - Counts in BUSY while o_wb_stb=1 and i_wb_ack=0.
  - Clears on ack, on leaving BUSY, and on timeout.
  - When the count equals TIMEOUT-1 and ack is still 0: o_mX_err=1 for exactly one cycle to the granted master, slave stb=0 that cycle, counter cleared.
  - Grant is kept until the master drops cyc.
  - If i_wb_ack and timeout coincide, ack wins and no err is raised.
- Ack/err exclusivity: never both 1 to the same master in one cycle.
- Ack with the granted master's stb=0 is ignored; it is not forwarded.
- Reset mid-transfer: outputs drop to 0 asynchronously. Any in-flight slave ack after reset is ignored (IDLE).
- Single requester: the same master may be re-granted after each release, always through one IDLE cycle.

Test Plan:
- Reset, then m0 cyc/stb read of adr 0x100; slave acks 2 cycles later with dat 0xDEADBEEF → o_grant 3→0 one cycle after request; o_m0_ack=1 with o_m0_dat=0xDEADBEEF; o_m1_ack=o_m2_ack=0.
- m0, m1, m2 all request continuously, each releasing after 1 acked transfer → grant order 0,1,2,0,1,2 with one IDLE cycle (o_grant=3) between grants.
- m1 holds cyc over 4 stb/ack beats (write, sel 4'b0011, dat 0x0000A5A5) while m0 requests → o_wb_we=1 and o_wb_sel=0011 on every beat; o_grant stays 1 for all 4; m0 granted only after m1 drops cyc.
- TIMEOUT=8, m2 strobes, slave never acks → o_m2_err=1 exactly on the 8th stalled cycle; o_wb_stb=0 that cycle; no ack; watchdog restarts if m2 keeps stb.
- TIMEOUT=8, slave acks on the 8th stalled cycle → o_m2_ack=1, o_m2_err=0.
- Assert i_rst for 1 cycle while m1 is granted mid-transfer → all o_wb_* and acks go 0 immediately; after release m0 (requesting) is granted first, because last_grant resets to 2.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Three-master to one-slave Wishbone classic arbiter with round-robin grants
// held for the whole CYC of the owner, plus a stall watchdog that raises a one-cycle error.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, slave outputs forced 0, arbitrating among requests
// BUSY  | owner holds the bus until it drops cyc; watchdog active
module wb_rr_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_sel,
    input  logic [29:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_dat,

    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    input  logic [29:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_dat,

    input  logic        i_m2_cyc,
    input  logic        i_m2_stb,
    input  logic        i_m2_we,
    input  logic [3:0]  i_m2_sel,
    input  logic [29:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    output logic        o_m2_ack,
    output logic        o_m2_err,
    output logic [31:0] o_m2_dat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,

    output logic [1:0]  o_grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0]       NO_GRANT  = 2'd3;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [1:0]       grant, grant_nxt;
    logic [1:0]       last_grant, last_grant_nxt;
    logic [CNT_W-1:0] wdog, wdog_nxt;
    logic             timeout;
    logic             busy;

    logic [2:0]       m_cyc, m_stb, m_we;
    logic [2:0][3:0]  m_sel;
    logic [2:0][29:0] m_adr;
    logic [2:0][31:0] m_dat;

    logic             g_cyc, g_stb, g_we;
    logic [3:0]       g_sel;
    logic [29:0]      g_adr;
    logic [31:0]      g_dat;

    logic [2:0]       ack_v, err_v;

    assign m_cyc = {i_m2_cyc, i_m1_cyc, i_m0_cyc};
    assign m_stb = {i_m2_stb, i_m1_stb, i_m0_stb};
    assign m_we  = {i_m2_we,  i_m1_we,  i_m0_we};
    assign m_sel = {i_m2_sel, i_m1_sel, i_m0_sel};
    assign m_adr = {i_m2_adr, i_m1_adr, i_m0_adr};
    assign m_dat = {i_m2_dat, i_m1_dat, i_m0_dat};

    // First requester after last_grant, wrapping modulo 3; NO_GRANT if none.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] pick;
        int         idx;
        pick = NO_GRANT;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant == 2'(i)) begin
                g_cyc = m_cyc[i];
                g_stb = m_stb[i];
                g_we  = m_we[i];
                g_sel = m_sel[i];
                g_adr = m_adr[i];
                g_dat = m_dat[i];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        wdog_nxt       = wdog;
        timeout        = 1'b0;
        case (state)
            IDLE: begin
                wdog_nxt = '0;
                if (|m_cyc) begin
                    state_nxt = BUSY;
                    grant_nxt = rr_pick(last_grant, m_cyc);
                end
            end
            BUSY: begin
                // An ack in the terminal cycle wins over the forced error.
                timeout = g_stb && !i_wb_ack && (wdog == WDOG_LAST);
                if (!g_cyc) begin
                    state_nxt      = IDLE;
                    grant_nxt      = NO_GRANT;
                    last_grant_nxt = grant;
                    wdog_nxt       = '0;
                end else if (i_wb_ack || timeout) begin
                    wdog_nxt = '0;
                end else if (g_stb) begin
                    wdog_nxt = wdog + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = NO_GRANT;
                wdog_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            grant      <= NO_GRANT;
            last_grant <= 2'd2;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
        end
    end

    assign busy     = (state == BUSY);
    assign o_grant  = grant;

    assign o_wb_cyc = busy & g_cyc;
    assign o_wb_stb = busy & g_stb & ~timeout;
    assign o_wb_we  = busy & g_we;
    assign o_wb_sel = busy ? g_sel : '0;
    assign o_wb_adr = busy ? g_adr : '0;
    assign o_wb_dat = busy ? g_dat : '0;

    // Ack is only forwarded while the owner is strobing; stray acks are dropped.
    always_comb begin
        ack_v = '0;
        err_v = '0;
        for (int i = 0; i < 3; i++) begin
            ack_v[i] = busy && (grant == 2'(i)) && i_wb_ack && m_stb[i];
            err_v[i] = timeout && (grant == 2'(i));
        end
    end

    assign o_m0_ack = ack_v[0];
    assign o_m1_ack = ack_v[1];
    assign o_m2_ack = ack_v[2];
    assign o_m0_err = err_v[0];
    assign o_m1_err = err_v[1];
    assign o_m2_err = err_v[2];

    assign o_m0_dat = i_wb_dat;
    assign o_m1_dat = i_wb_dat;
    assign o_m2_dat = i_wb_dat;

endmodule
